// File: rtl/conv_seq_pkg.sv
// Shared types and sizing helpers for the convolution frame sequencer.
//
// Contents:
//   seq_state_e : sequencer states (idle, feed, drain, done)
//   CountW      : width of the conv output counter
//   pad_dim()   : padded frame dimension for a given image size and border
//   cnt_w()     : counter width able to hold the values 0..n-1
package conv_seq_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFeed  = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } seq_state_e;

   localparam int unsigned CountW = 16;

   function automatic int unsigned pad_dim(input int unsigned n, input int unsigned p);
      return n + 2 * p;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/conv_pad_addr_gen.sv
// Raster position generator for a zero-padded image frame.
//
// Walks (row, col) over the padded frame, TW x TH positions, in raster order.
// Each advance moves to the next position and wraps to (0,0) after the last one.
//
// Ports:
//   clk_i      : clock
//   rst_i      : asynchronous active-high reset
//   clear_i    : return to position (0,0); takes priority over advance_i
//   advance_i  : step to the next raster position
//   interior_o : current position lies inside the unpadded image
//   last_o     : current position is the final one, (TH-1, TW-1)
//   addr_o     : image memory address of the current interior position
module conv_pad_addr_gen
   import conv_seq_pkg::*;
#(
   parameter int unsigned IMG_W   = 28,
   parameter int unsigned IMG_H   = 28,
   parameter int unsigned PADDING = 1,
   parameter int unsigned ADDR_W  = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              clear_i,
   input  logic              advance_i,
   output logic              interior_o,
   output logic              last_o,
   output logic [ADDR_W-1:0] addr_o
);

   localparam int unsigned TW = pad_dim(IMG_W, PADDING);
   localparam int unsigned TH = pad_dim(IMG_H, PADDING);
   localparam int unsigned RW = cnt_w(TH);
   localparam int unsigned CW = cnt_w(TW);

   localparam logic [RW-1:0] RowLo   = RW'(PADDING);
   localparam logic [RW-1:0] RowHi   = RW'(PADDING + IMG_H);
   localparam logic [RW-1:0] RowLast = RW'(TH - 1);
   localparam logic [CW-1:0] ColLo   = CW'(PADDING);
   localparam logic [CW-1:0] ColHi   = CW'(PADDING + IMG_W);
   localparam logic [CW-1:0] ColLast = CW'(TW - 1);

   logic [RW-1:0]     row_q, row_d;
   logic [CW-1:0]     col_q, col_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              interior;
   logic              last_pos;

   assign interior = (row_q >= RowLo) && (row_q < RowHi) && (col_q >= ColLo) && (col_q < ColHi);
   assign last_pos = (row_q == RowLast) && (col_q == ColLast);

   // Interior pixels are visited in raster order, so the memory address is a plain
   // running count of interior positions rather than (r-P)*W + (c-P).
   always_comb begin
      row_d  = row_q;
      col_d  = col_q;
      addr_d = addr_q;
      if (clear_i) begin
         row_d  = '0;
         col_d  = '0;
         addr_d = '0;
      end else if (advance_i) begin
         if (interior) begin
            addr_d = addr_q + ADDR_W'(1);
         end
         if (col_q == ColLast) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         if (last_pos) begin
            addr_d = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         row_q  <= '0;
         col_q  <= '0;
         addr_q <= '0;
      end else begin
         row_q  <= row_d;
         col_q  <= col_d;
         addr_q <= addr_d;
      end
   end

   assign interior_o = interior;
   assign last_o     = last_pos;
   assign addr_o     = addr_q;

endmodule

// File: rtl/conv_frame_sequencer.sv
// Streams one zero-padded image frame into the first convolution layer and
// counts the layer's outputs until the frame is complete.
//
// Optional feature: define SEQ_TIMEOUT_EN to abort DRAIN with err_o=1 after
// TIMEOUT_CYC cycles without a conv output. Without it DRAIN waits forever and
// err_o is tied low.
//
// Ports:
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   start_i           : frame start request (sampled in idle only)
//   hold_i            : pause issuing frame positions while high
//   busy_o            : frame in progress (feed or drain)
//   done_o            : one-cycle frame completion pulse
//   err_o             : sticky timeout flag, cleared by the next accepted start
//   mem_rd_en_o       : image memory read strobe
//   mem_addr_o        : image memory address, row*IMG_W+col
//   mem_rd_data_i     : image memory data, valid one cycle after the strobe
//   conv_in_valid_o   : pixel strobe to the conv layer
//   conv_in_data_o    : pixel value to the conv layer
//   conv_out_valid_i  : conv layer output strobe
//   out_count_o       : conv outputs counted in the current frame
module conv_frame_sequencer
   import conv_seq_pkg::*;
#(
   parameter int unsigned IMG_W       = 28,
   parameter int unsigned IMG_H       = 28,
   parameter int unsigned PADDING     = 1,
   parameter int unsigned EXP_OUT     = 784,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned ADDR_W      = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              hold_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [7:0]        mem_rd_data_i,
   output logic              conv_in_valid_o,
   output logic [7:0]        conv_in_data_o,
   input  logic              conv_out_valid_i,
   output logic [15:0]       out_count_o
);

   localparam logic [CountW-1:0] ExpOut = CountW'(EXP_OUT);

   seq_state_e        state_q;
   logic              busy_q;
   logic              done_q;
   logic              pix_vld_q;
   logic              pix_pad_q;
   logic [CountW-1:0] out_count_q, out_count_d;

   logic              issue;
   logic              gen_clear;
   logic              interior;
   logic              last_pos;
   logic [ADDR_W-1:0] gen_addr;
   logic              count_en;
   logic              count_done;

   conv_pad_addr_gen #(
      .IMG_W   (IMG_W),
      .IMG_H   (IMG_H),
      .PADDING (PADDING),
      .ADDR_W  (ADDR_W)
   ) u_addr_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clear_i    (gen_clear),
      .advance_i  (issue),
      .interior_o (interior),
      .last_o     (last_pos),
      .addr_o     (gen_addr)
   );

   // A position is issued in the same cycle hold_i is low, so the read strobe
   // follows hold_i directly; that keeps a hold cycle to exactly one lost slot.
   assign issue     = (state_q == StFeed) && !hold_i;
   assign gen_clear = (state_q == StIdle) && start_i;
   assign count_en  = ((state_q == StFeed) || (state_q == StDrain)) && conv_out_valid_i;

   always_comb begin
      out_count_d = out_count_q;
      if (count_en && (out_count_q != '1)) begin
         out_count_d = out_count_q + CountW'(1);
      end
   end

   // Looks at the next count so done lands one cycle after the final output.
   assign count_done = (out_count_d >= ExpOut);

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned IdleW = cnt_w(TIMEOUT_CYC);
   // Firing on TIMEOUT_CYC-1 places the done pulse TIMEOUT_CYC cycles after
   // the last conv output (or after DRAIN entry).
   localparam logic [IdleW-1:0] IdleLimit = IdleW'(TIMEOUT_CYC - 1);

   logic [IdleW-1:0] idle_q, idle_d;
   logic             err_q;
   logic             timeout;

   assign idle_d  = conv_out_valid_i ? '0 : idle_q + IdleW'(1);
   assign timeout = (idle_d == IdleLimit);
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pix_vld_q   <= 1'b0;
         pix_pad_q   <= 1'b0;
         out_count_q <= '0;
`ifdef SEQ_TIMEOUT_EN
         idle_q      <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         done_q    <= 1'b0;
         pix_vld_q <= issue;
         pix_pad_q <= ~interior;
         case (state_q)
            StIdle: begin
               if (start_i) begin
                  state_q     <= StFeed;
                  busy_q      <= 1'b1;
                  out_count_q <= '0;
`ifdef SEQ_TIMEOUT_EN
                  err_q       <= 1'b0;
`endif
               end
            end
            StFeed: begin
               out_count_q <= out_count_d;
               if (issue && last_pos) begin
                  state_q <= StDrain;
`ifdef SEQ_TIMEOUT_EN
                  idle_q  <= '0;
`endif
               end
            end
            StDrain: begin
               out_count_q <= out_count_d;
`ifdef SEQ_TIMEOUT_EN
               idle_q      <= idle_d;
`endif
               if (count_done) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
`ifdef SEQ_TIMEOUT_EN
               else if (timeout) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end
`endif
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign busy_o          = busy_q;
   assign done_o          = done_q;
`ifdef SEQ_TIMEOUT_EN
   assign err_o           = err_q;
`else
   assign err_o           = 1'b0;
`endif
   assign mem_rd_en_o     = issue && interior;
   assign mem_addr_o      = gen_addr;
   assign out_count_o     = out_count_q;
   assign conv_in_valid_o = pix_vld_q;
   // Memory data is already registered by the memory; the flopped pad flag
   // selects it or a zero without adding a pipeline stage.
   assign conv_in_data_o  = (pix_vld_q && !pix_pad_q) ? mem_rd_data_i : 8'h00;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed bench for conv_frame_sequencer on a 4x4 image with a 1-pixel border.
// Image memory model returns data = address, one cycle after the read strobe.
module tb_conv_frame_sequencer;

   localparam int unsigned IMG_W       = 4;
   localparam int unsigned IMG_H       = 4;
   localparam int unsigned PADDING     = 1;
   localparam int unsigned EXP_OUT     = 16;
   localparam int unsigned TIMEOUT_CYC = 20;
   localparam int unsigned ADDR_W      = 4;
   localparam int          TW          = 6;
   localparam int          NPOS        = 36;
   localparam int          LOG_N       = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              hold = 1'b0;
   logic              conv_out_valid = 1'b0;
   logic              busy, done, err, mem_rd_en, conv_in_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rd_data = 8'h00;
   logic [7:0]        conv_in_data;
   logic [15:0]       out_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = -1;

   logic        log_vld  [LOG_N];
   logic [7:0]  log_dat  [LOG_N];
   logic        log_rd   [LOG_N];
   logic        log_done [LOG_N];
   logic        log_busy [LOG_N];
   logic        log_err  [LOG_N];
   logic [15:0] log_cnt  [LOG_N];

   conv_frame_sequencer #(
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .PADDING     (PADDING),
      .EXP_OUT     (EXP_OUT),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .ADDR_W      (ADDR_W)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .hold_i           (hold),
      .busy_o           (busy),
      .done_o           (done),
      .err_o            (err),
      .mem_rd_en_o      (mem_rd_en),
      .mem_addr_o       (mem_addr),
      .mem_rd_data_i    (mem_rd_data),
      .conv_in_valid_o  (conv_in_valid),
      .conv_in_data_o   (conv_in_data),
      .conv_out_valid_i (conv_out_valid),
      .out_count_o      (out_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= {4'b0000, mem_addr};
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Advance into the next cycle, drive that cycle's inputs, then log outputs.
   task automatic step(input logic st, input logic hd, input logic ov);
      @(posedge clk);
      #1;
      cyc++;
      start          = st;
      hold           = hd;
      conv_out_valid = ov;
      #1;
      if (cyc >= 0 && cyc < LOG_N) begin
         log_vld[cyc]  = conv_in_valid;
         log_dat[cyc]  = conv_in_data;
         log_rd[cyc]   = mem_rd_en;
         log_done[cyc] = done;
         log_busy[cyc] = busy;
         log_err[cyc]  = err;
         log_cnt[cyc]  = out_count;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      start = 1'b0;
      hold = 1'b0;
      conv_out_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [7:0] exp_pix(input int p);
      int r, c;
      r = p / TW;
      c = p % TW;
      if (r >= 1 && r <= 4 && c >= 1 && c <= 4) return 8'((r - 1) * 4 + (c - 1));
      return 8'h00;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n_vld, n_rd, first, last, j;

      // Reset state, then conv outputs in idle must not count.
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_vld", conv_in_valid, 0);
      check_eq("rst_cnt", out_count, 0);
      rst = 1'b0;
      cyc = -1;
      for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      check_eq("idle_cnt", out_count, 0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_done", done, 0);
      check_eq("idle_err", err, 0);
      check_eq("idle_rd", mem_rd_en, 0);
      check_eq("idle_addr", mem_addr, 0);
      check_eq("idle_data", conv_in_data, 0);

      // Full frame, 16 conv outputs at cycles 35..50, start in DONE ignored.
      cyc = -1;
      step(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 60; k++) step(k == 51, 1'b0, (k >= 35 && k <= 50));
      n_vld = 0; n_rd = 0; first = -1; last = -1;
      for (int k = 0; k <= 60; k++) begin
         if (log_vld[k]) begin
            n_vld++;
            if (first < 0) first = k;
            last = k;
         end
         if (log_rd[k]) n_rd++;
      end
      check_eq("ff_busy0", log_busy[0], 0);
      check_eq("ff_busy1", log_busy[1], 1);
      check_eq("ff_nvld", n_vld, NPOS);
      check_eq("ff_first", first, 2);
      check_eq("ff_last", last, 37);
      check_eq("ff_nrd", n_rd, 16);
      for (int p = 0; p < NPOS; p++) check_eq($sformatf("ff_pix%0d", p), log_dat[p + 2], exp_pix(p));
      check_eq("ff_done50", log_done[50], 0);
      check_eq("ff_done51", log_done[51], 1);
      check_eq("ff_done52", log_done[52], 0);
      check_eq("ff_busy50", log_busy[50], 1);
      check_eq("ff_busy51", log_busy[51], 0);
      check_eq("ff_cnt51", log_cnt[51], 16);
      check_eq("ff_busy53", log_busy[53], 0);
      check_eq("ff_cnt53", log_cnt[53], 16);
      check_eq("ff_err51", log_err[51], 0);

      // Hold for cycles 5..7.
      cyc = -1;
      step(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 45; k++) step(1'b0, (k >= 5 && k <= 7), 1'b0);
      check_eq("hd_vld5", log_vld[5], 1);
      check_eq("hd_vld6", log_vld[6], 0);
      check_eq("hd_vld7", log_vld[7], 0);
      check_eq("hd_vld8", log_vld[8], 0);
      check_eq("hd_vld9", log_vld[9], 1);
      check_eq("hd_vld40", log_vld[40], 1);
      check_eq("hd_vld41", log_vld[41], 0);
      j = 0;
      for (int k = 0; k <= 45; k++) begin
         if (log_vld[k]) begin
            if (j < NPOS) check_eq($sformatf("hd_pix%0d", j), log_dat[k], exp_pix(j));
            j++;
         end
      end
      check_eq("hd_nvld", j, NPOS);

      // Still waiting in drain; reset, then reset again in the middle of a frame.
      do_reset();
      cyc = -1;
      step(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 9; k++) step(1'b0, 1'b0, 1'b0);
      check_eq("mr_vld9", log_vld[9], 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_eq("mr_vld", conv_in_valid, 0);
      check_eq("mr_busy", busy, 0);
      check_eq("mr_rd", mem_rd_en, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc = -1;
      for (int k = 0; k < 12; k++) step(1'b0, 1'b0, 1'b0);
      n_vld = 0; n_rd = 0;
      for (int k = 0; k < 12; k++) begin
         if (log_vld[k]) n_vld++;
         if (log_rd[k]) n_rd++;
      end
      check_eq("mr_post_vld", n_vld, 0);
      check_eq("mr_post_rd", n_rd, 0);
      check_eq("mr_post_busy", busy, 0);

`ifdef SEQ_TIMEOUT_EN
      // Only 10 outputs (last at cycle 44): timeout done at cycle 64.
      cyc = -1;
      step(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 70; k++) step(k == 66, 1'b0, (k >= 35 && k <= 44));
      check_eq("to_done63", log_done[63], 0);
      check_eq("to_done64", log_done[64], 1);
      check_eq("to_err63", log_err[63], 0);
      check_eq("to_err64", log_err[64], 1);
      check_eq("to_busy64", log_busy[64], 0);
      check_eq("to_cnt64", log_cnt[64], 10);
      check_eq("to_err66", log_err[66], 1);
      check_eq("to_err67", log_err[67], 0);
      check_eq("to_busy67", log_busy[67], 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
